// File: rtl/audio_sample_fifo.sv
// Circular PCM sample FIFO drained by I2S word-clock (AUD_LRCK) edges.
// Define AUDIO_FIFO_MONO_EN to pop on LRCK rising edges only; default pops on both edges.
module audio_sample_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                AUD_XCK,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [15:0]         wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic                AUD_LRCK,
  output logic [15:0]         audiodata,
  output logic [DEPTH_LOG2:0] level,
  output logic                underrun
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef logic [DEPTH_LOG2:0] ptr_t;

  logic [15:0] mem_q [Depth];
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        level_q, level_d;
  logic [15:0] audiodata_q, audiodata_d;
  logic        underrun_q, underrun_d;
  logic        lrck_q;

  logic full, empty, lrck_rise, lrck_fall, pop_evt, do_wr, do_rd;

  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign lrck_rise = AUD_LRCK && !lrck_q;
  assign lrck_fall = !AUD_LRCK && lrck_q;

`ifdef AUDIO_FIFO_MONO_EN
  assign pop_evt = lrck_rise;
`else
  assign pop_evt = lrck_rise || lrck_fall;
`endif

  // No write-to-read bypass: a pop on an empty FIFO underruns even if a write lands this cycle.
  assign do_wr = wr_valid && !full;
  assign do_rd = pop_evt && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    audiodata_d = audiodata_q;
    underrun_d  = underrun_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      audiodata_d = '0;
      underrun_d  = 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (pop_evt) begin
        if (empty) begin
          audiodata_d = '0;
          underrun_d  = 1'b1;
        end else begin
          audiodata_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
          rd_ptr_d    = rd_ptr_q + ptr_t'(1);
        end
      end
      unique case ({do_wr, do_rd})
        2'b10:   level_d = level_q + ptr_t'(1);
        2'b01:   level_d = level_q - ptr_t'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge AUD_XCK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      audiodata_q <= '0;
      underrun_q  <= 1'b0;
      lrck_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      audiodata_q <= audiodata_d;
      underrun_q  <= underrun_d;
      lrck_q      <= AUD_LRCK;
    end
  end

  // Sample storage needs no reset; contents are only read behind valid pointers.
  always_ff @(posedge AUD_XCK) begin
    if (do_wr && !clear) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  assign wr_ready  = !full;
  assign audiodata = audiodata_q;
  assign level     = level_q;
  assign underrun  = underrun_q;

endmodule
